// File: rtl/frame_sync_pkg.sv
// Shared types and constants for the frame synchroniser: FSM states,
// default sync word, length-field width and the mismatch-count helper.
package frame_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LENGTH  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACF_FC1D;
  localparam int          LEN_WIDTH         = 8;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/frame_sync_correlator.sv
// Sliding-window sync detector: keeps the most recent bits and flags a match
// when the window (including the incoming bit) is within MAX_ERR of the pattern.
module sync_correlator
  import frame_sync_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
  parameter int          SYNC_WIDTH = 32,
  parameter int          MAX_ERR    = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic clear,
  input  logic bit_in,
  output logic match
);

  localparam int                    FW       = $clog2(SYNC_WIDTH + 1);
  localparam logic [FW-1:0]         FILL_MAX = FW'(SYNC_WIDTH);
  localparam logic [FW-1:0]         FILL_MIN = FW'(SYNC_WIDTH - 1);
  localparam logic [FW-1:0]         FILL_ONE = FW'(1);
  localparam logic [5:0]            ERR_LIM  = 6'(MAX_ERR);
  localparam logic [SYNC_WIDTH-1:0] PATTERN  = SYNC_WORD[SYNC_WIDTH-1:0];

  logic [SYNC_WIDTH-1:0] sr;
  logic [SYNC_WIDTH-1:0] sr_next;
  logic [FW-1:0]         fill;
  logic [31:0]           diff;
  logic                  unused_msb;

  assign unused_msb = sr[SYNC_WIDTH-1];

  // Candidate window and threshold compare, evaluated on the bit being accepted
  always_comb begin
    sr_next = {sr[SYNC_WIDTH-2:0], bit_in};
    diff    = 32'd0;
    diff[SYNC_WIDTH-1:0] = sr_next ^ PATTERN;
    match   = shift_en && (fill >= FILL_MIN) && (popcount32(diff) <= ERR_LIM);
  end

  // Shift register and saturating fill counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      fill <= '0;
    end else if (clear) begin
      sr   <= '0;
      fill <= '0;
    end else if (shift_en) begin
      sr <= sr_next;
      if (fill != FILL_MAX) begin
        fill <= fill + FILL_ONE;
      end
    end
  end

endmodule

// File: rtl/frame_sync.sv
// Bit-stream frame synchroniser: hunts for the sync word, reads a one-byte
// length and emits the payload as an AXIS byte packet with tlast on the final byte.
module frame_sync
  import frame_sync_pkg::*;
#(
  parameter int          C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
  parameter logic [31:0] SYNC_WORD              = DEFAULT_SYNC_WORD,
  parameter int          SYNC_WIDTH             = 32,
  parameter int          MAX_ERR                = 0,
  parameter int          MAX_LEN                = 255
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  locked
);

  localparam int                   OW        = C_M00_AXIS_TDATA_WIDTH;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN_B = LEN_WIDTH'(MAX_LEN);
  localparam logic [2:0]           LAST_BIT  = 3'd7;

  state_t               state;
  state_t               state_next;
  logic [2:0]           bit_cnt;
  logic [2:0]           bit_cnt_next;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] len_next;
  logic [7:0]           acc;
  logic [7:0]           acc_next;
  logic [LEN_WIDTH-1:0] byte_cnt;
  logic [LEN_WIDTH-1:0] byte_cnt_next;
  logic [OW-1:0]        load_data;
  logic                 load;
  logic                 load_last;
  logic                 clear_sync;
  logic                 shift_sync;
  logic                 match;
  logic                 in_hs;
  logic                 out_hs;
  logic                 bit_in;
  logic                 unused_inputs;

  assign s00_axis_tready = m00_axis_tready | ~m00_axis_tvalid;
  assign in_hs           = s00_axis_tvalid & s00_axis_tready;
  assign out_hs          = m00_axis_tvalid & m00_axis_tready;
  assign bit_in          = s00_axis_tdata[0];
  assign m00_axis_tstrb  = '1;
  assign shift_sync      = in_hs && (state == SEARCH);
  assign unused_inputs   = ^{s00_axis_tlast, s00_axis_tstrb,
                             s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:1], len[7], acc[7]};

  sync_correlator #(
    .SYNC_WORD  (SYNC_WORD),
    .SYNC_WIDTH (SYNC_WIDTH),
    .MAX_ERR    (MAX_ERR)
  ) u_corr (
    .clk      (s00_axis_aclk),
    .rst_n    (s00_axis_aresetn),
    .shift_en (shift_sync),
    .clear    (clear_sync),
    .bit_in   (bit_in),
    .match    (match)
  );

  // Next-state and datapath decode; nothing moves without an input handshake
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    len_next      = len;
    acc_next      = acc;
    byte_cnt_next = byte_cnt;
    load          = 1'b0;
    load_last     = 1'b0;
    clear_sync    = 1'b0;
    if (in_hs) begin
      case (state)
        SEARCH: begin
          if (match) begin
            state_next   = LENGTH;
            bit_cnt_next = 3'd0;
          end else begin
            state_next = SEARCH;
          end
        end
        LENGTH: begin
          len_next     = {len[6:0], bit_in};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
            if ((len_next == 8'd0) || (len_next > MAX_LEN_B)) begin
              state_next = SEARCH;
              clear_sync = 1'b1;
            end else begin
              state_next    = PAYLOAD;
              byte_cnt_next = len_next;
            end
          end else begin
            state_next = LENGTH;
          end
        end
        PAYLOAD: begin
          acc_next     = {acc[6:0], bit_in};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
            load          = 1'b1;
            load_last     = (byte_cnt == 8'd1);
            byte_cnt_next = byte_cnt - 8'd1;
            if (byte_cnt == 8'd1) begin
              state_next = SEARCH;
              clear_sync = 1'b1;
            end else begin
              state_next = PAYLOAD;
            end
          end else begin
            state_next = PAYLOAD;
          end
        end
        default: begin
          state_next   = SEARCH;
          bit_cnt_next = 3'd0;
          clear_sync   = 1'b1;
        end
      endcase
    end else begin
      state_next = state;
    end
    load_data      = '0;
    load_data[7:0] = acc_next;
  end

  // Frame state and lock indication
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state    <= SEARCH;
      bit_cnt  <= 3'd0;
      len      <= '0;
      acc      <= 8'd0;
      byte_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      len      <= len_next;
      acc      <= acc_next;
      byte_cnt <= byte_cnt_next;
      locked   <= (state_next != SEARCH);
    end
  end

  // One-entry output register; a load during out_hs replaces the held byte
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
    end else if (load) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tlast  <= load_last;
      m00_axis_tdata  <= load_data;
    end else if (out_hs) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_sync.sv
// Directed bench for frame_sync: one instance with default tolerances and one
// with MAX_ERR=1 / MAX_LEN=16, selected per test, against hand-written byte lists.
module tb_frame_sync;

  localparam logic [31:0] SYNC = 32'h1ACF_FC1D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        m_tready = 1'b1;
  int          sel;
  int          bp_mode;
  int          n_checks;
  int          n_errors;
  logic [8:0]  got_q[$];
  logic [8:0]  exp_q[$];
  logic        locked_seen;
  logic [7:0]  t1_bytes [3];

  logic        a_s_tvalid, a_s_tready, a_m_tready, a_m_tvalid, a_m_tlast, a_locked;
  logic [31:0] a_m_tdata;
  logic [3:0]  a_m_tstrb;
  logic        b_s_tvalid, b_s_tready, b_m_tready, b_m_tvalid, b_m_tlast, b_locked;
  logic [31:0] b_m_tdata;
  logic [3:0]  b_m_tstrb;

  logic        cur_s_tready, cur_m_tvalid, cur_m_tlast, cur_locked;
  logic [31:0] cur_m_tdata;
  logic [3:0]  cur_m_tstrb;

  always #5 clk = ~clk;

  assign a_s_tvalid   = s_tvalid & (sel == 0);
  assign b_s_tvalid   = s_tvalid & (sel == 1);
  assign a_m_tready   = (sel == 0) ? m_tready : 1'b1;
  assign b_m_tready   = (sel == 1) ? m_tready : 1'b1;
  assign cur_s_tready = (sel == 0) ? a_s_tready : b_s_tready;
  assign cur_m_tvalid = (sel == 0) ? a_m_tvalid : b_m_tvalid;
  assign cur_m_tlast  = (sel == 0) ? a_m_tlast  : b_m_tlast;
  assign cur_m_tdata  = (sel == 0) ? a_m_tdata  : b_m_tdata;
  assign cur_m_tstrb  = (sel == 0) ? a_m_tstrb  : b_m_tstrb;
  assign cur_locked   = (sel == 0) ? a_locked   : b_locked;

  frame_sync dut_a (
    .s00_axis_aclk (clk), .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid (a_s_tvalid), .s00_axis_tlast (1'b0), .s00_axis_tdata (s_tdata),
    .s00_axis_tstrb (4'hF), .s00_axis_tready (a_s_tready),
    .m00_axis_tready (a_m_tready), .m00_axis_tvalid (a_m_tvalid), .m00_axis_tlast (a_m_tlast),
    .m00_axis_tdata (a_m_tdata), .m00_axis_tstrb (a_m_tstrb), .locked (a_locked)
  );

  frame_sync #(.MAX_ERR(1), .MAX_LEN(16)) dut_b (
    .s00_axis_aclk (clk), .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid (b_s_tvalid), .s00_axis_tlast (1'b0), .s00_axis_tdata (s_tdata),
    .s00_axis_tstrb (4'hF), .s00_axis_tready (b_s_tready),
    .m00_axis_tready (b_m_tready), .m00_axis_tvalid (b_m_tvalid), .m00_axis_tlast (b_m_tlast),
    .m00_axis_tdata (b_m_tdata), .m00_axis_tstrb (b_m_tstrb), .locked (b_locked)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Downstream side: drives tready per mode and records each beat that will handshake
  initial begin
    forever begin
      @(negedge clk);
      case (bp_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
      #2;
      if (rst_n && cur_locked) locked_seen = 1'b1;
      if (rst_n && cur_m_tvalid && m_tready) got_q.push_back({cur_m_tlast, cur_m_tdata[7:0]});
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    logic hs;
    int   guard;
    hs = 1'b0;
    guard = 0;
    s_tdata  = {31'd0, b};
    s_tvalid = 1'b1;
    while (!hs) begin
      @(negedge clk);
      #1;
      hs = cur_s_tready;
      @(posedge clk);
      if (!hs) begin
        guard++;
        if (guard > 2000) begin
          check("stall_timeout", 32'd1, 32'd0);
          hs = 1'b1;
        end
      end
    end
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic push_exp(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  task automatic drain(input string tag);
    int g;
    bp_mode = 0;
    g = 0;
    while (cur_m_tvalid && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_drained"}, 32'(cur_m_tvalid), 32'd0);
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] d0;
    logic        ok_r, ok_d;
    int          g;
    n_checks = 0;
    n_errors = 0;
    sel = 0;
    bp_mode = 0;
    s_tvalid = 1'b0;
    s_tdata = 32'd0;
    locked_seen = 1'b0;
    t1_bytes = '{8'hA5, 8'h3C, 8'hFF};
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(cur_m_tvalid), 32'd0);
    check("rst_tlast", 32'(cur_m_tlast), 32'd0);
    check("rst_tdata", cur_m_tdata, 32'd0);
    check("rst_locked", 32'(cur_locked), 32'd0);
    check("rst_tstrb", 32'(cur_m_tstrb), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame with per-byte latency and lock-drop checks
    send_rand(40);
    send_word(SYNC);
    check("clean_lock", 32'(cur_locked), 32'd1);
    send_byte(8'h03);
    for (int k = 0; k < 3; k++) begin
      b = t1_bytes[k];
      for (int i = 7; i >= 1; i--) send_bit(b[i]);
      check($sformatf("clean_prevalid%0d", k), 32'(cur_m_tvalid), 32'd0);
      check($sformatf("clean_prelock%0d", k), 32'(cur_locked), 32'd1);
      send_bit(b[0]);
      check($sformatf("clean_valid%0d", k), 32'(cur_m_tvalid), 32'd1);
      check($sformatf("clean_data%0d", k), cur_m_tdata, {24'd0, b});
      check($sformatf("clean_last%0d", k), 32'(cur_m_tlast), (k == 2) ? 32'd1 : 32'd0);
    end
    check("clean_unlock", 32'(cur_locked), 32'd0);
    drain("clean");
    push_exp(8'hA5, 1'b0); push_exp(8'h3C, 1'b0); push_exp(8'hFF, 1'b1);
    check_stream("clean");

    // Tolerance on the MAX_ERR=1 instance
    sel = 1;
    send_rand(40);
    send_word(SYNC ^ 32'h0010_0000);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    drain("err1");
    push_exp(8'h12, 1'b0); push_exp(8'h34, 1'b1);
    check_stream("err1");
    locked_seen = 1'b0;
    send_word(SYNC ^ 32'h8000_0001);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    drain("err2");
    check_stream("err2");
    check("err2_never_locked", 32'(locked_seen), 32'd0);

    // Length above MAX_LEN rejected, following frame still decodes
    send_word(SYNC);
    send_byte(8'h20);
    check("maxlen_unlock", 32'(cur_locked), 32'd0);
    send_word(SYNC);
    send_byte(8'h02); send_byte(8'hDE); send_byte(8'hAD);
    drain("maxlen");
    push_exp(8'hDE, 1'b0); push_exp(8'hAD, 1'b1);
    check_stream("maxlen");

    // Zero length rejected
    sel = 0;
    send_word(SYNC);
    send_byte(8'h00);
    check("len0_unlock", 32'(cur_locked), 32'd0);
    send_byte(8'hA5); send_byte(8'hA5);
    drain("len0");
    check_stream("len0");

    // Downstream held off for 20 cycles after the first byte
    fork
      begin
        send_word(SYNC);
        send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      end
      begin
        g = 0;
        while (!cur_m_tvalid && g < 2000) begin
          @(posedge clk);
          #1;
          g++;
        end
        bp_mode = 2;
        check("bp_wait_valid", 32'(cur_m_tvalid), 32'd1);
        d0 = cur_m_tdata;
        ok_r = 1'b1;
        ok_d = 1'b1;
        repeat (20) begin
          @(negedge clk);
          #3;
          if (cur_s_tready) ok_r = 1'b0;
          if ((cur_m_tdata !== d0) || !cur_m_tvalid) ok_d = 1'b0;
        end
        check("bp_tready_low", 32'(ok_r), 32'd1);
        check("bp_tdata_stable", 32'(ok_d), 32'd1);
        check("bp_first_byte", d0, 32'h11);
        bp_mode = 0;
      end
    join
    drain("bp");
    push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b0); push_exp(8'h33, 1'b1);
    check_stream("bp");

    // 255-byte frame under random downstream ready
    bp_mode = 1;
    send_word(SYNC);
    send_byte(8'hFF);
    for (int i = 0; i < 255; i++) begin
      b = 8'($urandom);
      push_exp(b, (i == 254));
      send_byte(b);
    end
    drain("rand");
    check_stream("rand");

    // Asynchronous reset during byte 2 of 5
    send_word(SYNC);
    send_byte(8'h05);
    send_byte(8'h11);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst_tvalid", 32'(cur_m_tvalid), 32'd0);
    check("mrst_tlast", 32'(cur_m_tlast), 32'd0);
    check("mrst_tdata", cur_m_tdata, 32'd0);
    check("mrst_locked", 32'(cur_locked), 32'd0);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mrst_no_stale", 32'(cur_m_tvalid), 32'd0);
    push_exp(8'h11, 1'b0);
    check_stream("mrst");
    send_rand(16);
    send_word(SYNC);
    send_byte(8'h02); send_byte(8'h5A); send_byte(8'hC3);
    drain("post_rst");
    push_exp(8'h5A, 1'b0); push_exp(8'hC3, 1'b1);
    check_stream("post_rst");

    // Sync word inside the payload is plain data
    send_word(SYNC);
    send_byte(8'h06);
    send_byte(8'h1A); send_byte(8'hCF); send_byte(8'hFC); send_byte(8'h1D); send_byte(8'h55);
    check("insync_locked", 32'(cur_locked), 32'd1);
    send_byte(8'h77);
    drain("insync");
    push_exp(8'h1A, 1'b0); push_exp(8'hCF, 1'b0); push_exp(8'hFC, 1'b0);
    push_exp(8'h1D, 1'b0); push_exp(8'h55, 1'b0); push_exp(8'h77, 1'b1);
    check_stream("insync");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_sync.md
Name: frame_sync

Overview:
- Stream stage directly downstream of the differential bit decoder: consumes one decoded bit per AXIS beat (tdata[0]).
- Hunts for a sync word with a configurable Hamming-error tolerance, then reads a one-byte length field.
- Packs the following payload bits MSB-first into bytes and emits them as an AXIS packet, with tlast on the final byte.
- Feeds the packet/byte consumer of the receive chain.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32: input bus width; only bit 0 is used.
- C_M00_AXIS_TDATA_WIDTH, 32: output bus width; the byte is on [7:0], upper bits are 0.
- SYNC_WORD, 32'h1ACF_FC1D: sync pattern, MSB received first.
- SYNC_WIDTH, 32: number of sync bits, 8..32.
- MAX_ERR, 0: maximum allowed bit mismatches for a sync match, 0..3.
- MAX_LEN, 255: largest accepted payload length in bytes, 1..255.

Ports:
- s00_axis_aclk  in  1  clock
- s00_axis_aresetn  in  1  asynchronous active-low reset
- s00_axis_tvalid  in  1  input bit valid
- s00_axis_tlast  in  1  ignored
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  [0] is the decoded bit
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored
- s00_axis_tready  out  1  ready for an input bit
- m00_axis_tready  in  1  downstream ready
- m00_axis_tvalid  out  1  output byte valid
- m00_axis_tlast  out  1  last payload byte of the frame
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  {zeros, byte}
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant all-ones
- locked  out  1  high while state is LENGTH or PAYLOAD

Behaviour:
- Reset: one clock; asynchronous, active-low reset on s00_axis_aresetn. It forces state=SEARCH and clears the shift register, fill counter, bit counter, byte counter, m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata and locked, all to 0. Reset mid-frame discards the frame with no partial output. m00_axis_tstrb is all-ones at all times.
- Handshake: s00_axis_tready = m00_axis_tready | ~m00_axis_tvalid.
  - in_hs = s00_axis_tvalid & s00_axis_tready.
  - out_hs = m00_axis_tvalid & m00_axis_tready.
  - All state advances occur only on in_hs.
- Output register: one-entry output register.
  - A byte is loaded on the in_hs that completes it; m00_axis_tvalid is set the next cycle, i.e. latency is 1 clock after the 8th bit's handshake.
  - On out_hs with no simultaneous load, tvalid clears.
  - A simultaneous load and out_hs replaces the register and keeps tvalid=1.
- SEARCH:
  - Each in_hs shifts the bit into the SYNC_WIDTH-bit register: sr <= {sr[W-2:0], bit}.
  - The fill counter saturates at SYNC_WIDTH.
  - Match condition: the fill counter is at least SYNC_WIDTH-1 before the shift, and popcount({sr[W-2:0],bit} ^ SYNC_WORD) <= MAX_ERR.
  - On a match, the state goes to LENGTH with the bit counter at 0, and locked=1 on the next cycle.
- LENGTH:
  - Shifts 8 bits MSB-first into len. On the 8th bit, len_next is evaluated.
  - If len_next is 0 or greater than MAX_LEN, the state returns to SEARCH with no output.
  - Otherwise, the state goes to PAYLOAD with byte_cnt = len_next.
- PAYLOAD:
  - Shifts bits MSB-first into the byte accumulator. On the 8th bit, the byte is loaded to the output with tlast = (byte_cnt==1), and byte_cnt decrements.
  - When byte_cnt reaches 0, the state returns to SEARCH.
- Returning to SEARCH from any state clears sr and the fill counter, so sync must be re-found from fresh bits.
- Bits that arrive while m00_axis_tvalid=1 and m00_axis_tready=0 stall via tready. No bit is ever dropped.
- A sync pattern inside the payload is ignored: no re-sync occurs while locked.

Decomposition:
- Shared package holds:
  - the state enum typedef (SEARCH, LENGTH, PAYLOAD);
  - the default SYNC_WORD constant;
  - the length-field width constant (8).
- One sub-module: sync_correlator. It contains the shift register, the fill counter and the popcount-threshold compare, and produces a single-cycle match signal combinationally from the incoming bit.

Test Plan:
- Clean frame: 40 random bits, then 0x1ACFFC1D, then length 0x03, then bytes A5 3C FF, with tready=1.
  - Required: three beats tdata=0xA5, 0x3C, 0xFF; tlast only on 0xFF; each beat 1 clock after its 8th bit.
  - Required: locked falls after the last bit.
- Error tolerance with MAX_ERR=1:
  - Sync with 1 bit flipped -> frame is decoded.
  - Sync with 2 bits flipped -> no output, locked stays 0.
- Length rejection:
  - Length 0x00 -> no output, back to SEARCH.
  - With MAX_LEN=16, length 0x20 -> no output. A following valid frame still decodes.
- Backpressure:
  - Hold m00_axis_tready=0 for 20 cycles after the first byte is valid. Required: s00_axis_tready=0 throughout, tdata stable, no bytes lost.
  - Random tready toggling over a 255-byte frame -> output matches the reference byte stream exactly.
- Mid-frame reset:
  - Assert aresetn=0 asynchronously (between clock edges) during byte 2 of 5. Required: all outputs 0 immediately; no stale byte after release.
  - The next full frame decodes correctly.
- Sync pattern inside the payload: payload containing 1ACFFC1D -> emitted verbatim as payload bytes, no re-lock.
